// File: rtl/cw310_reg_crypt_batch_if.sv
// Register bus and crypto-core signals of the batched crypto register block.
// slave = the register block itself, master = host + core side.
interface cw310_reg_crypt_batch_if #(
   parameter int pADDR_WIDTH   = 21,
   parameter int pBYTECNT_SIZE = 7,
   parameter int pPT_WIDTH     = 128,
   parameter int pCT_WIDTH     = 128,
   parameter int pKEY_WIDTH    = 128
);
   logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
   logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
   logic [7:0]                           read_data;
   logic [7:0]                           write_data;
   logic                                 reg_read;
   logic                                 reg_write;
   logic                                 reg_addrvalid;
   logic [pCT_WIDTH-1:0]                 I_cipherout;
   logic                                 I_ready;
   logic                                 I_done;
   logic [pKEY_WIDTH-1:0]                O_key;
   logic [pPT_WIDTH-1:0]                 O_textin;
   logic                                 O_start;
   logic                                 O_batch_busy;
   logic [2:0]                           batch_state;   // sequencer state, debug only

   // Register strobes are single-cycle and qualified by reg_addrvalid; O_start is a
   // one-cycle request, I_done (edge or level) is the core's completion answer.
   modport slave (
      input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
      input  I_cipherout, I_ready, I_done,
      output read_data, O_key, O_textin, O_start, O_batch_busy, batch_state
   );
   modport master (
      output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
      output I_cipherout, I_ready, I_done,
      input  read_data, O_key, O_textin, O_start, O_batch_busy, batch_state
   );
endinterface

// File: rtl/cw310_reg_crypt_batch.sv
// Batched crypto register block: plaintext FIFO -> sequencer -> ciphertext FIFO.
// Optional macro CRYPT_TIMEOUT_EN bounds the WAIT state to pTIMEOUT cycles.
module cw310_reg_crypt_batch #(
   parameter int pADDR_WIDTH          = 21,
   parameter int pBYTECNT_SIZE        = 7,
   parameter int pPT_WIDTH            = 128,
   parameter int pCT_WIDTH            = 128,
   parameter int pKEY_WIDTH           = 128,
   parameter int pDEPTH               = 8,
   parameter int pDONE_EDGE_SENSITIVE = 1,
   parameter int pTIMEOUT             = 4096
) (
   input logic                      usb_clk,
   input logic                      reset_i,
   cw310_reg_crypt_batch_if.slave   bus
);
   localparam int AW        = $clog2(pDEPTH);
   localparam int RA_W      = pADDR_WIDTH - pBYTECNT_SIZE;
   localparam int KEY_BYTES = pKEY_WIDTH / 8;
   localparam int PT_BYTES  = pPT_WIDTH / 8;
   localparam int CT_BYTES  = pCT_WIDTH / 8;

   localparam logic [RA_W-1:0] REG_CRYPT_TEXTIN    = RA_W'(6);
   localparam logic [RA_W-1:0] REG_CRYPT_CIPHEROUT = RA_W'(9);
   localparam logic [RA_W-1:0] REG_CRYPT_KEY       = RA_W'(10);
   localparam logic [RA_W-1:0] REG_BATCH_CTRL      = RA_W'(16);
   localparam logic [RA_W-1:0] REG_BATCH_PUSH      = RA_W'(17);
   localparam logic [RA_W-1:0] REG_BATCH_POP       = RA_W'(18);
   localparam logic [RA_W-1:0] REG_BATCH_STATUS    = RA_W'(19);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STORE} state_t;
   state_t state, state_nxt;

   logic [pKEY_WIDTH-1:0] key_r;
   logic [pPT_WIDTH-1:0]  stage_r, textin_r;
   logic [pPT_WIDTH-1:0]  in_mem  [pDEPTH];
   logic [pCT_WIDTH-1:0]  out_mem [pDEPTH];
   logic [AW:0]           in_wptr, in_rptr, out_wptr, out_rptr, in_cnt, out_cnt;
   logic                  in_full, in_empty, out_full, out_empty;
   logic                  run, ovf, unf, tmo, done_q, done_evt, tmo_hit;
   logic [15:0]           op_cnt;
   logic [pBYTECNT_SIZE+2:0] bit_idx;
   logic                  wr, ctrl_wr, flush, push_ok, push_drop, pop_ok, pop_bad, store, in_pop;

   assign bit_idx   = {bus.reg_bytecnt, 3'b000};
   assign in_cnt    = in_wptr - in_rptr;
   assign out_cnt   = out_wptr - out_rptr;
   assign in_empty  = (in_wptr == in_rptr);
   assign out_empty = (out_wptr == out_rptr);
   assign in_full   = (in_wptr[AW] != in_rptr[AW]) && (in_wptr[AW-1:0] == in_rptr[AW-1:0]);
   assign out_full  = (out_wptr[AW] != out_rptr[AW]) && (out_wptr[AW-1:0] == out_rptr[AW-1:0]);

   assign wr        = bus.reg_addrvalid && bus.reg_write;
   assign ctrl_wr   = wr && (bus.reg_address == REG_BATCH_CTRL) && (bus.reg_bytecnt == '0);
   assign flush     = ctrl_wr && bus.write_data[1];
   // Full/empty come from the pre-cycle pointers, so a same-cycle FSM pop never frees room.
   assign push_ok   = wr && (bus.reg_address == REG_BATCH_PUSH) && !in_full && !flush;
   assign push_drop = wr && (bus.reg_address == REG_BATCH_PUSH) && in_full && !flush;
   assign pop_ok    = wr && (bus.reg_address == REG_BATCH_POP) && !out_empty && !flush;
   assign pop_bad   = wr && (bus.reg_address == REG_BATCH_POP) && out_empty && !flush;
   assign store     = (state == S_STORE) && !flush;
   assign in_pop    = (store || tmo_hit) && !flush;
   assign done_evt  = (pDONE_EDGE_SENSITIVE != 0) ? (bus.I_done && !done_q) : bus.I_done;

`ifdef CRYPT_TIMEOUT_EN
   localparam int TW = $clog2(pTIMEOUT) + 1;
   logic [TW-1:0] tmo_cnt;
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i)               tmo_cnt <= '0;
      else if (state != S_WAIT)  tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;
   end
   assign tmo_hit = (state == S_WAIT) && !done_evt && (tmo_cnt == TW'(pTIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (run && !in_empty && !out_full && bus.I_ready) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (done_evt) state_nxt = S_STORE;
                  else if (tmo_hit) state_nxt = S_IDLE;
         S_STORE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_comb begin
      bus.O_start      = (state == S_START);
      bus.O_batch_busy = (state != S_IDLE);
      bus.batch_state  = state;
   end

   always_ff @(posedge usb_clk) begin
      if (push_ok) in_mem[in_wptr[AW-1:0]]   <= stage_r;
      if (store)   out_mem[out_wptr[AW-1:0]] <= bus.I_cipherout;
   end

   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         key_r <= '0; stage_r <= '0; textin_r <= '0; run <= 1'b0; done_q <= 1'b0;
         in_wptr <= '0; in_rptr <= '0; out_wptr <= '0; out_rptr <= '0;
         ovf <= 1'b0; unf <= 1'b0; tmo <= 1'b0; op_cnt <= '0;
      end else begin
         done_q <= bus.I_done;
         if (wr && bus.reg_address == REG_CRYPT_KEY && int'(bus.reg_bytecnt) < KEY_BYTES)
            key_r[bit_idx +: 8] <= bus.write_data;
         if (wr && bus.reg_address == REG_CRYPT_TEXTIN && int'(bus.reg_bytecnt) < PT_BYTES)
            stage_r[bit_idx +: 8] <= bus.write_data;
         if (ctrl_wr) run <= bus.write_data[0];
         if (state == S_LOAD) textin_r <= in_mem[in_rptr[AW-1:0]];
         if (flush) begin
            in_wptr <= '0; in_rptr <= '0; out_wptr <= '0; out_rptr <= '0;
            ovf <= 1'b0; unf <= 1'b0; tmo <= 1'b0;
         end else begin
            if (push_ok)   in_wptr <= in_wptr + 1'b1;
            if (push_drop) ovf <= 1'b1;
            if (in_pop)    in_rptr <= in_rptr + 1'b1;
            if (tmo_hit)   tmo <= 1'b1;
            if (store) begin
               out_wptr <= out_wptr + 1'b1;
               op_cnt   <= op_cnt + 1'b1;
            end
            if (pop_ok)  out_rptr <= out_rptr + 1'b1;
            if (pop_bad) unf <= 1'b1;
         end
      end
   end

   assign bus.O_key    = key_r;
   assign bus.O_textin = textin_r;

   logic [pCT_WIDTH-1:0] out_head;
   assign out_head = out_mem[out_rptr[AW-1:0]];

   always_comb begin
      bus.read_data = '0;
      if (bus.reg_addrvalid && bus.reg_read) begin
         case (bus.reg_address)
            REG_CRYPT_KEY:
               if (int'(bus.reg_bytecnt) < KEY_BYTES) bus.read_data = key_r[bit_idx +: 8];
            REG_CRYPT_TEXTIN:
               if (int'(bus.reg_bytecnt) < PT_BYTES) bus.read_data = stage_r[bit_idx +: 8];
            REG_CRYPT_CIPHEROUT:
               if (!out_empty && int'(bus.reg_bytecnt) < CT_BYTES)
                  bus.read_data = out_head[bit_idx +: 8];
            REG_BATCH_CTRL:
               if (bus.reg_bytecnt == '0) bus.read_data = {7'b0, run};
            REG_BATCH_STATUS:
               case (int'(bus.reg_bytecnt))
                  0: bus.read_data = {bus.O_batch_busy, tmo, unf, ovf,
                                      out_empty, out_full, in_empty, in_full};
                  1: bus.read_data = 8'(in_cnt);
                  2: bus.read_data = 8'(out_cnt);
                  3: bus.read_data = op_cnt[7:0];
                  4: bus.read_data = op_cnt[15:8];
                  default: bus.read_data = '0;
               endcase
            default: bus.read_data = '0;
         endcase
      end
   end
endmodule
